// File: rtl/ecb_pkg.sv
// Shared types and helpers for the row-parallel ECB XOR cipher sequencer.
//   state_t : sequencer states (IDLE, FILL, CRYPT, DRAIN)
//   wpr()   : number of BLOCK_SIZE-bit words that make up one HSIZE-bit row
package ecb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CRYPT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int wpr(input int hsize, input int block_size);
    return hsize / block_size;
  endfunction

endpackage

// File: rtl/ecb_row_xor.sv
// Combinational ECB XOR datapath for one full row.
// Every BLOCK_SIZE-bit slice of the row is XORed with the same key, so
// row_out[i] = row_in[i] ^ key[i % BLOCK_SIZE]. The same block decrypts.
// Ports:
//   key     in  BLOCK_SIZE  frame key
//   row_in  in  HSIZE       plaintext (or ciphertext) row
//   row_out out HSIZE       ciphertext (or plaintext) row
module ecb_row_xor
  import ecb_pkg::*;
#(
  parameter int BLOCK_SIZE = 32,
  parameter int HSIZE      = 768
) (
  input  logic [BLOCK_SIZE-1:0] key,
  input  logic [HSIZE-1:0]      row_in,
  output logic [HSIZE-1:0]      row_out
);

  localparam int WPR = wpr(HSIZE, BLOCK_SIZE);

  for (genvar w = 0; w < WPR; w++) begin : g_word
    assign row_out[w*BLOCK_SIZE +: BLOCK_SIZE] = row_in[w*BLOCK_SIZE +: BLOCK_SIZE] ^ key;
  end

endmodule

// File: rtl/ecb_row_ctrl.sv
// Frame-level sequencer for the row-parallel ECB XOR cipher.
// Collects a row of plaintext words, encrypts the whole row in one cycle,
// then streams the ciphertext row out. Rows never overlap: the next row is
// only accepted once the previous one has fully drained.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         frame start pulse, honoured only when idle
//   key, bypass   frame key and plaintext pass-through, latched on start
//   s_valid/s_ready/s_data                     plaintext input stream
//   m_valid/m_ready/m_data                     ciphertext output stream
//   m_last_word   last word of the current output row
//   m_last_row    current row is the last row of the frame
//   busy          sequencer is not idle
//   frame_done    one-cycle pulse after the final word of the frame leaves
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; no stream activity
// FILL  | accepting input words into row_buf
// CRYPT | one cycle: load ct_buf from datapath (or row_buf on bypass)
// DRAIN | presenting ct_buf words on the output stream
module ecb_row_ctrl
  import ecb_pkg::*;
#(
  parameter int BLOCK_SIZE = 32,
  parameter int HSIZE      = 768,
  parameter int VSIZE      = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BLOCK_SIZE-1:0] key,
  input  logic                  bypass,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BLOCK_SIZE-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BLOCK_SIZE-1:0] m_data,
  output logic                  m_last_word,
  output logic                  m_last_row,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int WPR = wpr(HSIZE, BLOCK_SIZE);
  // Keep counters at least one bit wide for degenerate one-word / one-row sizes.
  localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RCW = (VSIZE > 1) ? $clog2(VSIZE) : 1;
  localparam logic [WCW-1:0] WORD_LAST = WCW'(WPR - 1);
  localparam logic [RCW-1:0] ROW_LAST  = RCW'(VSIZE - 1);

  if (HSIZE % BLOCK_SIZE != 0) begin : g_size_check
    $error("ecb_row_ctrl: HSIZE must be a multiple of BLOCK_SIZE");
  end

  state_t                state, state_nxt;
  logic [WCW-1:0]        word_cnt;
  logic [RCW-1:0]        row_cnt;
  logic [BLOCK_SIZE-1:0] key_q;
  logic                  bypass_q;
  logic [HSIZE-1:0]      row_buf;
  logic [HSIZE-1:0]      ct_buf;
  logic [HSIZE-1:0]      xor_row;
  logic                  s_fire;
  logic                  m_fire;
  logic                  word_last;
  logic                  row_last;

  assign word_last = (word_cnt == WORD_LAST);
  assign row_last  = (row_cnt == ROW_LAST);
  assign s_fire    = s_valid && s_ready;
  assign m_fire    = m_valid && m_ready;

  ecb_row_xor #(
    .BLOCK_SIZE(BLOCK_SIZE),
    .HSIZE     (HSIZE)
  ) u_row_xor (
    .key    (key_q),
    .row_in (row_buf),
    .row_out(xor_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last_word = 1'b0;
    m_last_row  = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FILL;
      end
      FILL: begin
        s_ready    = 1'b1;
        m_last_row = row_last;
        if (s_valid && word_last) state_nxt = CRYPT;
      end
      CRYPT: begin
        m_last_row = row_last;
        state_nxt  = DRAIN;
      end
      DRAIN: begin
        m_valid     = 1'b1;
        m_data      = ct_buf[word_cnt*BLOCK_SIZE +: BLOCK_SIZE];
        m_last_word = word_last;
        m_last_row  = row_last;
        if (m_ready && word_last) state_nxt = row_last ? IDLE : FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt   <= '0;
      row_cnt    <= '0;
      key_q      <= '0;
      bypass_q   <= 1'b0;
      row_buf    <= '0;
      ct_buf     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_q    <= key;
            bypass_q <= bypass;
            row_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        FILL: begin
          if (s_fire) begin
            row_buf[word_cnt*BLOCK_SIZE +: BLOCK_SIZE] <= s_data;
            word_cnt <= word_last ? '0 : word_cnt + 1'b1;
          end
        end
        CRYPT: begin
          ct_buf <= bypass_q ? row_buf : xor_row;
        end
        DRAIN: begin
          if (m_fire) begin
            word_cnt <= word_last ? '0 : word_cnt + 1'b1;
            if (word_last) begin
              if (row_last) frame_done <= 1'b1;
              else          row_cnt    <= row_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecb_row_ctrl.sv
module tb_ecb_row_ctrl;

  localparam int BS = 32;
  localparam int HS = 96;
  localparam int VS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BS-1:0] key;
  logic          bypass;
  logic          s_valid;
  logic          s_ready;
  logic [BS-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [BS-1:0] m_data;
  logic          m_last_word;
  logic          m_last_row;
  logic          busy;
  logic          frame_done;

  ecb_row_ctrl #(.BLOCK_SIZE(BS), .HSIZE(HS), .VSIZE(VS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .bypass     (bypass),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last_word(m_last_word),
    .m_last_row (m_last_row),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BS-1:0] data;
    logic          lw;
    logic          lr;
    logic          lf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   word_idx = 0;
  logic fd_expected = 1'b0;

  task automatic check(input string name, input logic [BS-1:0] act, input logic [BS-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops one expectation per accepted output word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        fd_expected = 1'b0;
      end else begin
        if (frame_done || fd_expected) check("frame_done", frame_done, fd_expected);
        fd_expected = 1'b0;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected no word", m_data);
          end else begin
            e = exp_q.pop_front();
            check("m_data", m_data, e.data);
            check("m_last_word", m_last_word, e.lw);
            check("m_last_row", m_last_row, e.lr);
            fd_expected = e.lf;
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [BS-1:0] k, input logic b);
    @(negedge clk);
    start = 1'b1; key = k; bypass = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic frame_begin(input logic [BS-1:0] k, input logic b);
    word_idx = 0;
    pulse_start(k, b);
  endtask

  task automatic send(input logic [BS-1:0] d, input logic [BS-1:0] expd);
    exp_t e;
    int n;
    e.data = expd;
    e.lw   = (word_idx % 3 == 2);
    e.lr   = (word_idx >= 3);
    e.lf   = (word_idx == 5);
    exp_q.push_back(e);
    word_idx++;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("s_ready_timeout", s_ready, 1);
    end else begin
      @(posedge clk);
    end
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("frame_end_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BS-1:0] held;
    int n;
    rst = 1'b1; start = 1'b0; key = '0; bypass = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_m_data", m_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1. basic frame, plus latency of the crypt cycle
    frame_begin(32'hA5A5A5A5, 1'b0);
    check("busy_after_start", busy, 1);
    check("s_ready_fill", s_ready, 1);
    send(32'h0, 32'hA5A5A5A5);
    send(32'h0, 32'hA5A5A5A5);
    send(32'h0, 32'hA5A5A5A5);
    @(negedge clk);
    check("crypt_m_valid", m_valid, 0);
    check("crypt_s_ready", s_ready, 0);
    @(negedge clk);
    check("latency_m_valid", m_valid, 1);
    send(32'h0, 32'hA5A5A5A5);
    send(32'h0, 32'hA5A5A5A5);
    send(32'h0, 32'hA5A5A5A5);
    wait_idle();

    // 2. round trip
    frame_begin(32'hDEADBEEF, 1'b0);
    send(32'h12345678, 32'hCC99E897);
    send(32'hFFFFFFFF, 32'h21524110);
    send(32'h00000000, 32'hDEADBEEF);
    send(32'h12345678, 32'hCC99E897);
    send(32'hFFFFFFFF, 32'h21524110);
    send(32'h00000000, 32'hDEADBEEF);
    wait_idle();
    frame_begin(32'hDEADBEEF, 1'b0);
    send(32'hCC99E897, 32'h12345678);
    send(32'h21524110, 32'hFFFFFFFF);
    send(32'hDEADBEEF, 32'h00000000);
    send(32'hCC99E897, 32'h12345678);
    send(32'h21524110, 32'hFFFFFFFF);
    send(32'hDEADBEEF, 32'h00000000);
    wait_idle();

    // 3. bypass
    frame_begin(32'h13572468, 1'b1);
    send(32'hCAFEBABE, 32'hCAFEBABE);
    send(32'h00000000, 32'h00000000);
    send(32'hFFFFFFFF, 32'hFFFFFFFF);
    send(32'h12345678, 32'h12345678);
    send(32'h87654321, 32'h87654321);
    send(32'hA5A5A5A5, 32'hA5A5A5A5);
    wait_idle();

    // 4. backpressure mid-drain
    frame_begin(32'h0F0F0F0F, 1'b0);
    send(32'h00000001, 32'h0F0F0F0E);
    send(32'h10203040, 32'h1F2F3F4F);
    m_ready = 1'b0;
    send(32'hF0F0F0F0, 32'hFFFFFFFF);
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_up", m_valid, 1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    held = m_data;
    check("bp_second_word", held, 32'h1F2F3F4F);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_data", m_data, held);
      check("bp_hold_valid", m_valid, 1);
      check("bp_s_ready", s_ready, 0);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    send(32'hAAAAAAAA, 32'hA5A5A5A5);
    send(32'h55555555, 32'h5A5A5A5A);
    send(32'h0F0F0F0F, 32'h00000000);
    wait_idle();

    // 5. start during FILL is ignored
    frame_begin(32'h11111111, 1'b0);
    send(32'h01234567, 32'h10325476);
    pulse_start(32'h22222222, 1'b0);
    check("invalid_start_busy", busy, 1);
    send(32'h89ABCDEF, 32'h98BADCFE);
    send(32'h11111111, 32'h00000000);
    send(32'h22222222, 32'h33333333);
    send(32'hFFFFFFFF, 32'hEEEEEEEE);
    send(32'h00000000, 32'h11111111);
    wait_idle();

    // 6. reset mid-frame
    frame_begin(32'h5A5A5A5A, 1'b0);
    send(32'h11111111, 32'h4B4B4B4B);
    send(32'h22222222, 32'h78787878);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_last_word", m_last_word, 0);
    check("mid_rst_last_row", m_last_row, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame_begin(32'h5A5A5A5A, 1'b0);
    send(32'h00000000, 32'h5A5A5A5A);
    send(32'hFFFFFFFF, 32'hA5A5A5A5);
    send(32'h5A5A5A5A, 32'h00000000);
    send(32'hA5A5A5A5, 32'hFFFFFFFF);
    send(32'h12345678, 32'h486E0C22);
    send(32'h00000000, 32'h5A5A5A5A);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
